// File: rtl/gen_fifo_sched_pkg.sv
// Shared types and the round-robin pick helper for the gen_fifo pop scheduler.
package gen_fifo_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } sched_state_t;

  // Widest eligibility vector the pick helper handles; callers zero-extend.
  localparam int unsigned RR_MAX_Q = 32;

  // First set bit of elig, searching last+1, last+2, ... modulo n_q.
  function automatic int unsigned rr_pick(input logic [RR_MAX_Q-1:0] elig,
                                          input int unsigned last,
                                          input int unsigned n_q);
    int unsigned start;
    int unsigned idx;
    logic        found;
    rr_pick = 0;
    found   = 1'b0;
    start   = (last + 1 >= n_q) ? 0 : last + 1;
    for (int unsigned i = 0; i < RR_MAX_Q; i++) begin
      if (i < n_q) begin
        idx = start + i;
        if (idx >= n_q) idx = idx - n_q;
        if (!found && elig[idx[4:0]]) begin
          rr_pick = idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/gen_cnt_top.sv
// Clearable up-counter; clear wins over increment.
module gen_cnt_top #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/gen_fifo_pop_sched.sv
// Weighted round-robin pop scheduler: drains N_Q FIFOs onto one downstream port,
// serving up to cfg_burst entries per grant with a one-cycle arbitration bubble.
module gen_fifo_pop_sched
  import gen_fifo_sched_pkg::*;
#(
  parameter int N_Q     = 4,
  parameter int BURST_W = 4,
  localparam int QID_W  = $clog2(N_Q)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_Q-1:0]         cfg_en,
  input  logic [N_Q*BURST_W-1:0] cfg_burst,
  input  logic [N_Q-1:0]         q_empty,
  input  logic                   dst_rdy,
  output logic [N_Q-1:0]         pop,
  output logic                   out_vld,
  output logic [QID_W-1:0]       out_qid,
  output logic                   sts_busy,
  output logic [QID_W-1:0]       sts_cur_q
);

  // Handshake: pop[q] is a one-cycle request to queue q, only raised when
  // dst_rdy is high and q is enabled and non-empty; the entry appears on the
  // shared read data one cycle later, flagged by out_vld/out_qid.

  sched_state_t         state, state_nxt;
  logic [QID_W-1:0]     cur_q, cur_q_nxt;
  logic [QID_W-1:0]     last_q, last_q_nxt;
  logic [QID_W-1:0]     rr_next;
  logic [N_Q-1:0]       elig;
  logic [N_Q-1:0]       pop_c;
  logic [BURST_W-1:0]   burst_cnt;
  logic [BURST_W-1:0]   cur_burst;
  logic [BURST_W-1:0]   burst_lim_m1;
  logic                 cur_empty;
  logic                 cur_en;
  logic                 grant;
  logic                 exit_srv;
  logic                 pop_any;

  assign elig      = cfg_en & ~q_empty;
  assign cur_empty = q_empty[cur_q];
  assign cur_en    = cfg_en[cur_q];
  assign rr_next   = QID_W'(rr_pick(RR_MAX_Q'(elig), 32'(last_q), N_Q));

  always_comb begin
    cur_burst = '0;
    for (int q = 0; q < N_Q; q++) begin
      if (cur_q == QID_W'(q)) cur_burst = cfg_burst[q*BURST_W +: BURST_W];
    end
  end

  // A programmed burst of 0 behaves as a burst of 1.
  assign burst_lim_m1 = (cur_burst == '0) ? '0 : cur_burst - BURST_W'(1);

  always_comb begin
    state_nxt  = state;
    cur_q_nxt  = cur_q;
    last_q_nxt = last_q;
    grant      = 1'b0;
    exit_srv   = 1'b0;
    pop_c      = '0;
    case (state)
      IDLE: begin
        if (|elig) begin
          grant     = 1'b1;
          cur_q_nxt = rr_next;
          state_nxt = SERVE;
        end
      end
      SERVE: begin
        if (dst_rdy && !cur_empty && cur_en) pop_c[cur_q] = 1'b1;
        // >= so a mid-grant shrink of cfg_burst ends the grant on the next pop.
        exit_srv = cur_empty || !cur_en ||
                   ((|pop_c) && (burst_cnt >= burst_lim_m1));
        if (exit_srv) begin
          state_nxt  = IDLE;
          last_q_nxt = cur_q;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!rst_n) pop_c = '0;
  end

  assign pop     = pop_c;
  assign pop_any = |pop_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cur_q   <= '0;
      last_q  <= QID_W'(N_Q - 1);
      out_vld <= 1'b0;
      out_qid <= '0;
    end else begin
      state   <= state_nxt;
      cur_q   <= cur_q_nxt;
      last_q  <= last_q_nxt;
      out_vld <= pop_any;
      if (pop_any) out_qid <= cur_q;
    end
  end

  gen_cnt_top #(
    .CNT_W (BURST_W)
  ) u_burst_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (grant),
    .inc   (pop_any),
    .cnt   (burst_cnt)
  );

  assign sts_busy  = (state == SERVE);
  assign sts_cur_q = cur_q;

endmodule

// File: tb/tb_gen_fifo_pop_sched.sv
// Directed bench for gen_fifo_pop_sched: hand-computed pop sequences per cycle,
// plus an expected-queue scoreboard for the out_vld/out_qid pipe.
module tb_gen_fifo_pop_sched;

  localparam int N_Q     = 4;
  localparam int BURST_W = 4;
  localparam int QID_W   = 2;

  logic                   clk;
  logic                   rst_n;
  logic [N_Q-1:0]         cfg_en;
  logic [N_Q*BURST_W-1:0] cfg_burst;
  logic [N_Q-1:0]         q_empty;
  logic                   dst_rdy;
  logic [N_Q-1:0]         pop;
  logic                   out_vld;
  logic [QID_W-1:0]       out_qid;
  logic                   sts_busy;
  logic [QID_W-1:0]       sts_cur_q;

  int n_checks = 0;
  int n_errors = 0;
  logic [QID_W-1:0] exp_q[$];
  logic [N_Q-1:0]   prev_pop;

  gen_fifo_pop_sched #(
    .N_Q     (N_Q),
    .BURST_W (BURST_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_en    (cfg_en),
    .cfg_burst (cfg_burst),
    .q_empty   (q_empty),
    .dst_rdy   (dst_rdy),
    .pop       (pop),
    .out_vld   (out_vld),
    .out_qid   (out_qid),
    .sts_busy  (sts_busy),
    .sts_cur_q (sts_cur_q)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [QID_W-1:0] qidx(input logic [N_Q-1:0] v);
    qidx = '0;
    for (int i = 0; i < N_Q; i++) if (v[i]) qidx = QID_W'(i);
  endfunction

  // Reset for two edges; pop must stay low even if the FSM was mid-burst.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_pop0", 32'(pop), 32'h0);
    @(negedge clk);
    #1;
    check("rst_pop1", 32'(pop), 32'h0);
    check("rst_vld",  32'(out_vld), 32'h0);
    check("rst_qid",  32'(out_qid), 32'h0);
    check("rst_busy", 32'(sts_busy), 32'h0);
    check("rst_curq", 32'(sts_cur_q), 32'h0);
    @(negedge clk);
    rst_n    = 1'b1;
    prev_pop = '0;
    exp_q.delete();
  endtask

  // Driver + checker for one cycle, starting at a negedge.
  task automatic cyc(input logic [N_Q-1:0] empty, input logic [N_Q-1:0] en,
                     input logic rdy, input logic [N_Q-1:0] exp_pop,
                     input logic exp_busy, input logic [QID_W-1:0] exp_cur);
    q_empty = empty;
    cfg_en  = en;
    dst_rdy = rdy;
    #1;
    check("pop",  32'(pop), 32'(exp_pop));
    check("busy", 32'(sts_busy), 32'(exp_busy));
    if (exp_busy) check("cur_q", 32'(sts_cur_q), 32'(exp_cur));
    check("out_vld", 32'(out_vld), 32'(prev_pop != '0));
    if (prev_pop != '0) begin
      if (exp_q.size() == 0) check("sb_underrun", 32'h1, 32'h0);
      else check("out_qid", 32'(out_qid), 32'(exp_q.pop_front()));
    end
    if (exp_pop != '0) exp_q.push_back(qidx(exp_pop));
    prev_pop = exp_pop;
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    cfg_en    = '1;
    cfg_burst = {4'd2, 4'd2, 4'd2, 4'd2};
    q_empty   = '1;
    dst_rdy   = 1'b1;
    prev_pop  = '0;
    @(negedge clk);
    do_reset();

    // all queues empty: nothing ever granted
    for (int i = 0; i < 8; i++) cyc(4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0);

    // burst 2 everywhere: q0,q0,bubble,q1,q1,...,q3,q3, wraps to q0
    do_reset();
    for (int g = 0; g < 5; g++) begin
      cyc(4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0);
      cyc(4'h0, 4'hF, 1'b1, 4'(1 << (g % 4)), 1'b1, 2'(g % 4));
      cyc(4'h0, 4'hF, 1'b1, 4'(1 << (g % 4)), 1'b1, 2'(g % 4));
    end

    // q1 burst 3 but empties after one pop; next grant goes to q2
    do_reset();
    cfg_burst = {4'd1, 4'd1, 4'd3, 4'd1};
    cyc(4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0);
    cyc(4'h0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0);
    cyc(4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0);
    cyc(4'h0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1);
    cyc(4'h2, 4'hF, 1'b1, 4'h0, 1'b1, 2'd1);
    cyc(4'h2, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0);
    cyc(4'h2, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2);

    // dst_rdy low 5 cycles mid-burst: grant held, count preserved
    do_reset();
    cfg_burst = {4'd3, 4'd3, 4'd3, 4'd3};
    cyc(4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0);
    cyc(4'h0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0);
    for (int i = 0; i < 5; i++) cyc(4'h0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd0);
    cyc(4'h0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0);
    cyc(4'h0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0);
    cyc(4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0);
    cyc(4'h0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1);

    // only q1/q3 enabled, burst 0 acts as 1
    do_reset();
    cfg_burst = '0;
    for (int i = 0; i < 2; i++) begin
      cyc(4'h0, 4'hA, 1'b1, 4'h0, 1'b0, 2'd0);
      cyc(4'h0, 4'hA, 1'b1, 4'h2, 1'b1, 2'd1);
      cyc(4'h0, 4'hA, 1'b1, 4'h0, 1'b0, 2'd0);
      cyc(4'h0, 4'hA, 1'b1, 4'h8, 1'b1, 2'd3);
    end

    // burst shrunk mid-grant below current count: exit on next pop
    do_reset();
    cfg_burst = {4'd4, 4'd4, 4'd4, 4'd4};
    cyc(4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0);
    cyc(4'h0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0);
    cyc(4'h0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0);
    cfg_burst = {4'd4, 4'd4, 4'd4, 4'd2};
    cyc(4'h0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0);
    cyc(4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0);
    cyc(4'h0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1);

    // sync reset mid-burst on q1: next grant restarts at q0
    do_reset();
    cfg_burst = {4'd3, 4'd3, 4'd3, 4'd3};
    cyc(4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0);
    for (int i = 0; i < 3; i++) cyc(4'h0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0);
    cyc(4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0);
    cyc(4'h0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1);
    do_reset();
    cyc(4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0);
    cyc(4'h0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0);
    cyc(4'h0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
